// File: rtl/arm_reg_pkg.sv
// Shared encodings for the banked ARM7 register file: modes, CPSR fields,
// physical register layout and SPSR selection.
package arm_reg_pkg;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    localparam int CPSR_N    = 31;
    localparam int CPSR_Z    = 30;
    localparam int CPSR_C    = 29;
    localparam int CPSR_V    = 28;
    localparam int CPSR_I    = 7;
    localparam int CPSR_F    = 6;
    localparam int CPSR_M_HI = 4;
    localparam int CPSR_M_LO = 0;

    // 30 storage GPRs plus the pc make up the 31 physical registers.
    localparam int NUM_PHYS = 31;
    localparam int NUM_GPR  = 30;
    localparam logic [4:0] PHYS_PC = 5'd30;

    localparam logic [4:0] BASE_FIQ_R8  = 5'd15;
    localparam logic [4:0] BASE_IRQ_R13 = 5'd22;
    localparam logic [4:0] BASE_SVC_R13 = 5'd24;
    localparam logic [4:0] BASE_ABT_R13 = 5'd26;
    localparam logic [4:0] BASE_UND_R13 = 5'd28;

    typedef enum logic [2:0] {
        SPSR_FIQ  = 3'd0,
        SPSR_IRQ  = 3'd1,
        SPSR_SVC  = 3'd2,
        SPSR_ABT  = 3'd3,
        SPSR_UND  = 3'd4,
        SPSR_NONE = 3'd5
    } spsr_idx_e;

    localparam int NUM_SPSR = 5;

    function automatic logic is_valid_mode(input logic [4:0] m);
        case (m)
            MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
            MODE_ABT, MODE_UND, MODE_SYS: is_valid_mode = 1'b1;
            default:                      is_valid_mode = 1'b0;
        endcase
    endfunction

    function automatic spsr_idx_e spsr_sel(input logic [4:0] m);
        case (m)
            MODE_FIQ: spsr_sel = SPSR_FIQ;
            MODE_IRQ: spsr_sel = SPSR_IRQ;
            MODE_SVC: spsr_sel = SPSR_SVC;
            MODE_ABT: spsr_sel = SPSR_ABT;
            MODE_UND: spsr_sel = SPSR_UND;
            default:  spsr_sel = SPSR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/arm_bank_mapper.sv
// Combinational translation of (mode, architectural register) to physical index.
// r15 maps to the pc slot and raises is_pc_o; unknown modes fall back to the user bank.
module arm_bank_mapper
    import arm_reg_pkg::*;
(
    input  logic [4:0] mode_i,
    input  logic [3:0] arch_addr_i,
    output logic [4:0] phys_idx_o,
    output logic       is_pc_o
);

    logic [4:0] r13_r14_ofs;

    // r13 = 4'b1101, r14 = 4'b1110: bit 1 picks the slot within a two-register bank.
    assign r13_r14_ofs = {4'b0000, arch_addr_i[1]};

    always_comb begin
        phys_idx_o = {1'b0, arch_addr_i};
        is_pc_o    = 1'b0;
        if (arch_addr_i == 4'd15) begin
            phys_idx_o = PHYS_PC;
            is_pc_o    = 1'b1;
        end else if (mode_i == MODE_FIQ) begin
            if (arch_addr_i >= 4'd8) begin
                phys_idx_o = {1'b0, arch_addr_i} + (BASE_FIQ_R8 - 5'd8);
            end
        end else if (arch_addr_i >= 4'd13) begin
            case (mode_i)
                MODE_IRQ: phys_idx_o = BASE_IRQ_R13 + r13_r14_ofs;
                MODE_SVC: phys_idx_o = BASE_SVC_R13 + r13_r14_ofs;
                MODE_ABT: phys_idx_o = BASE_ABT_R13 + r13_r14_ofs;
                MODE_UND: phys_idx_o = BASE_UND_R13 + r13_r14_ofs;
                default:  phys_idx_o = {1'b0, arch_addr_i};
            endcase
        end
    end

endmodule

// File: rtl/arm_banked_register_file.sv
// ARM7 register file with mode banking, N banked read ports, a user-bank read port,
// pc stepping, CPSR/SPSR banking and single-edge exception entry/return.
module arm_banked_register_file
    import arm_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    NUM_RD_PORTS   = 3,
    parameter int                    PC_INCREMENT   = 4,
    parameter int                    PC_READ_OFFSET = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_PC       = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] RESET_CPSR     = 32'h0000_00D3,
    parameter int                    BYPASS         = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [4*NUM_RD_PORTS-1:0]          rd_addr,
    output logic [DATA_WIDTH*NUM_RD_PORTS-1:0] rd_data,
    input  logic [3:0]                         univ_rd_addr,
    output logic [DATA_WIDTH-1:0]              univ_rd_data,
    input  logic [3:0]                         wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic                               wr_en,
    input  logic [DATA_WIDTH-1:0]              pc_update,
    input  logic                               pc_write,
    input  logic                               pc_inc_en,
    input  logic [DATA_WIDTH-1:0]              cpsr_update,
    input  logic                               cpsr_write,
    input  logic [DATA_WIDTH-1:0]              spsr_update,
    input  logic                               spsr_write,
    input  logic                               exc_req,
    input  logic [4:0]                         exc_mode,
    input  logic [DATA_WIDTH-1:0]              exc_vector,
    input  logic [DATA_WIDTH-1:0]              exc_lr,
    input  logic                               exc_ret,
    output logic [DATA_WIDTH-1:0]              pc,
    output logic [DATA_WIDTH-1:0]              cpsr,
    output logic [DATA_WIDTH-1:0]              spsr,
    output logic                               mode_err
);

    localparam int DW = DATA_WIDTH;

    logic [DW-1:0] gpr_q  [NUM_GPR];
    logic [DW-1:0] gpr_d  [NUM_GPR];
    logic [DW-1:0] spsr_q [NUM_SPSR];
    logic [DW-1:0] spsr_d [NUM_SPSR];
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] cpsr_q, cpsr_d;
    logic          mode_err_q, mode_err_d;

    logic [4:0]    cur_mode;
    spsr_idx_e     cur_spsr, exc_spsr;
    logic          cur_has_spsr;
    logic [DW-1:0] pc_rd;

    logic [4:0]    wr_idx, exc_idx, univ_idx;
    logic          wr_is_pc, exc_is_pc, univ_is_pc;
    logic          wr_gpr;
    logic          exc_take, exc_bad;

    // Banking follows the registered cpsr, so a mode change takes effect next cycle.
    assign cur_mode     = cpsr_q[CPSR_M_HI:CPSR_M_LO];
    assign cur_spsr     = spsr_sel(cur_mode);
    assign cur_has_spsr = (cur_spsr != SPSR_NONE);
    assign exc_spsr     = spsr_sel(exc_mode);
    assign pc_rd        = pc_q + DW'(PC_READ_OFFSET);

    assign exc_take = exc_req && (exc_spsr != SPSR_NONE);
    assign exc_bad  = exc_req && (exc_spsr == SPSR_NONE);

    arm_bank_mapper u_map_wr (
        .mode_i      (cur_mode),
        .arch_addr_i (wr_addr),
        .phys_idx_o  (wr_idx),
        .is_pc_o     (wr_is_pc)
    );

    arm_bank_mapper u_map_exc (
        .mode_i      (exc_mode),
        .arch_addr_i (4'd14),
        .phys_idx_o  (exc_idx),
        .is_pc_o     (exc_is_pc)
    );

    arm_bank_mapper u_map_univ (
        .mode_i      (MODE_USR),
        .arch_addr_i (univ_rd_addr),
        .phys_idx_o  (univ_idx),
        .is_pc_o     (univ_is_pc)
    );

    assign wr_gpr = wr_en && !wr_is_pc;

    for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
        logic [4:0]    idx;
        logic          is_pc;
        logic [DW-1:0] word;

        arm_bank_mapper u_map_rd (
            .mode_i      (cur_mode),
            .arch_addr_i (rd_addr[4*k +: 4]),
            .phys_idx_o  (idx),
            .is_pc_o     (is_pc)
        );

        always_comb begin
            word = gpr_q[idx];
            if (is_pc) begin
                word = pc_rd;
            end else if ((BYPASS != 0) && wr_gpr && (wr_idx == idx)) begin
                word = wr_data;
            end
        end

        assign rd_data[DW*k +: DW] = word;
    end

    always_comb begin
        univ_rd_data = gpr_q[univ_idx];
        if (univ_is_pc) begin
            univ_rd_data = pc_rd;
        end else if ((BYPASS != 0) && wr_gpr && (wr_idx == univ_idx)) begin
            univ_rd_data = wr_data;
        end
    end

    // GPR next state: the exception r14 is applied last so it wins a collision.
    always_comb begin
        gpr_d = gpr_q;
        if (wr_gpr) begin
            gpr_d[wr_idx] = wr_data;
        end
        if (exc_take && !exc_is_pc) begin
            gpr_d[exc_idx] = exc_lr;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (exc_take) begin
            pc_d = exc_vector;
        end else if (wr_en && wr_is_pc) begin
            pc_d = wr_data;
        end else if (pc_write) begin
            pc_d = pc_update;
        end else if (pc_inc_en) begin
            pc_d = pc_q + DW'(PC_INCREMENT);
        end
    end

    // An illegal exception request drops out of the priority chain entirely.
    always_comb begin
        cpsr_d     = cpsr_q;
        mode_err_d = exc_bad;
        if (exc_take) begin
            cpsr_d[CPSR_I] = 1'b1;
            if (exc_mode == MODE_FIQ) begin
                cpsr_d[CPSR_F] = 1'b1;
            end
            cpsr_d[CPSR_M_HI:CPSR_M_LO] = exc_mode;
        end else if (exc_ret) begin
            if (cur_has_spsr && is_valid_mode(spsr_q[cur_spsr][CPSR_M_HI:CPSR_M_LO])) begin
                cpsr_d = spsr_q[cur_spsr];
            end else begin
                mode_err_d = 1'b1;
            end
        end else if (cpsr_write) begin
            if (is_valid_mode(cpsr_update[CPSR_M_HI:CPSR_M_LO])) begin
                cpsr_d = cpsr_update;
            end else begin
                mode_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        spsr_d = spsr_q;
        if (spsr_write && cur_has_spsr) begin
            spsr_d[cur_spsr] = spsr_update;
        end
        if (exc_take) begin
            spsr_d[exc_spsr] = cpsr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
            for (int i = 0; i < NUM_SPSR; i++) begin
                spsr_q[i] <= '0;
            end
            pc_q       <= RESET_PC;
            cpsr_q     <= RESET_CPSR;
            mode_err_q <= 1'b0;
        end else begin
            gpr_q      <= gpr_d;
            spsr_q     <= spsr_d;
            pc_q       <= pc_d;
            cpsr_q     <= cpsr_d;
            mode_err_q <= mode_err_d;
        end
    end

    always_comb begin
        pc       = pc_q;
        cpsr     = cpsr_q;
        mode_err = mode_err_q;
        spsr     = '0;
        if (cur_has_spsr) begin
            spsr = spsr_q[cur_spsr];
        end
    end

endmodule

// File: tb/tb_arm_banked_register_file.sv
// Directed bench for arm_banked_register_file: reset, pc stepping, banking,
// exception entry/return, illegal-mode handling and write bypass/collision.
module tb_arm_banked_register_file;

    logic        clk;
    logic        rst;
    logic [11:0] rd_addr;
    logic [95:0] rd_data;
    logic [3:0]  univ_rd_addr;
    logic [31:0] univ_rd_data;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [31:0] pc_update;
    logic        pc_write;
    logic        pc_inc_en;
    logic [31:0] cpsr_update;
    logic        cpsr_write;
    logic [31:0] spsr_update;
    logic        spsr_write;
    logic        exc_req;
    logic [4:0]  exc_mode;
    logic [31:0] exc_vector;
    logic [31:0] exc_lr;
    logic        exc_ret;
    logic [31:0] pc;
    logic [31:0] cpsr;
    logic [31:0] spsr;
    logic        mode_err;

    int n_checks = 0;
    int n_fail   = 0;

    arm_banked_register_file dut (
        .clk          (clk),
        .rst          (rst),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .univ_rd_addr (univ_rd_addr),
        .univ_rd_data (univ_rd_data),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .pc_update    (pc_update),
        .pc_write     (pc_write),
        .pc_inc_en    (pc_inc_en),
        .cpsr_update  (cpsr_update),
        .cpsr_write   (cpsr_write),
        .spsr_update  (spsr_update),
        .spsr_write   (spsr_write),
        .exc_req      (exc_req),
        .exc_mode     (exc_mode),
        .exc_vector   (exc_vector),
        .exc_lr       (exc_lr),
        .exc_ret      (exc_ret),
        .pc           (pc),
        .cpsr         (cpsr),
        .spsr         (spsr),
        .mode_err     (mode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench 1 ns after a rising edge, where outputs are stable and inputs may change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_en = 0; pc_write = 0; pc_inc_en = 0; cpsr_write = 0;
        spsr_write = 0; exc_req = 0; exc_ret = 0;
    endtask

    task automatic test_reset();
        logic [31:0] rd0;
        wr_en = 1; wr_addr = 4'd0; wr_data = 32'h5; pc_inc_en = 1;
        step();
        wr_en = 0;
        step();
        clear_inputs();
        #2;
        rst = 1;
        #1;
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_checks++; if (cpsr !== 32'hD3) begin n_fail++; $display("FAIL reset_cpsr: got %h want %h", cpsr, 32'hD3); end
        n_checks++; if (mode_err !== 1'b0) begin n_fail++; $display("FAIL reset_mode_err: got %b want 0", mode_err); end
        n_checks++; if (spsr !== 32'h0) begin n_fail++; $display("FAIL reset_spsr: got %h want 0", spsr); end
        for (int i = 0; i < 15; i++) begin
            rd_addr[3:0] = i[3:0];
            #1;
            rd0 = rd_data[31:0];
            n_checks++;
            if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_r%0d: got %h want 0", i, rd0); end
        end
        @(negedge clk);
        rst = 0;
        step();
    endtask

    task automatic test_pc_step();
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL pc_start: got %h want 0", pc); end
        pc_inc_en = 1;
        step();
        n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL pc_inc1: got %h want 4", pc); end
        step();
        n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL pc_inc2: got %h want 8", pc); end
        step();
        n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL pc_inc3: got %h want c", pc); end
        pc_inc_en = 0;
        rd_addr[3:0] = 4'd15;
        #1;
        n_checks++; if (rd_data[31:0] !== 32'h14) begin n_fail++; $display("FAIL r15_read: got %h want 14", rd_data[31:0]); end
        pc_write = 1; pc_update = 32'h100; pc_inc_en = 1;
        step();
        clear_inputs();
        n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL pc_write_over_inc: got %h want 100", pc); end
        wr_en = 1; wr_addr = 4'd15; wr_data = 32'h40; pc_write = 1; pc_update = 32'h80;
        step();
        clear_inputs();
        n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL pc_wr_r15_over_write: got %h want 40", pc); end
        pc_write = 1; pc_update = 32'hFFFF_FFFC;
        step();
        clear_inputs();
        #1;
        n_checks++; if (rd_data[31:0] !== 32'h4) begin n_fail++; $display("FAIL r15_read_wrap: got %h want 4", rd_data[31:0]); end
        pc_inc_en = 1;
        step();
        clear_inputs();
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL pc_wrap: got %h want 0", pc); end
    endtask

    task automatic test_banking();
        wr_en = 1; wr_addr = 4'd13; wr_data = 32'hAAAA;
        step();
        wr_addr = 4'd8; wr_data = 32'h88;
        step();
        wr_en = 0; cpsr_write = 1; cpsr_update = 32'h10;
        step();
        clear_inputs();
        n_checks++; if (cpsr !== 32'h10) begin n_fail++; $display("FAIL bank_to_usr: got %h want 10", cpsr); end
        wr_en = 1; wr_addr = 4'd13; wr_data = 32'h5555;
        step();
        clear_inputs();
        rd_addr = {4'd0, 4'd8, 4'd13};
        univ_rd_addr = 4'd13;
        #1;
        n_checks++; if (rd_data[31:0] !== 32'h5555) begin n_fail++; $display("FAIL usr_r13: got %h want 5555", rd_data[31:0]); end
        n_checks++; if (univ_rd_data !== 32'h5555) begin n_fail++; $display("FAIL univ_r13: got %h want 5555", univ_rd_data); end
        n_checks++; if (rd_data[63:32] !== 32'h88) begin n_fail++; $display("FAIL usr_r8: got %h want 88", rd_data[63:32]); end
        n_checks++; if (spsr !== 32'h0) begin n_fail++; $display("FAIL usr_spsr_zero: got %h want 0", spsr); end
        cpsr_write = 1; cpsr_update = 32'h13;
        step();
        clear_inputs();
        rd_addr = {4'd13, 4'd8, 4'd13};
        #1;
        n_checks++; if (rd_data[95:64] !== 32'hAAAA) begin n_fail++; $display("FAIL svc_r13: got %h want aaaa", rd_data[95:64]); end
        n_checks++; if (univ_rd_data !== 32'h5555) begin n_fail++; $display("FAIL svc_univ_r13: got %h want 5555", univ_rd_data); end
    endtask

    task automatic test_fiq_entry();
        cpsr_write = 1; cpsr_update = 32'h10; pc_write = 1; pc_update = 32'h200;
        step();
        clear_inputs();
        n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL fiq_setup_pc: got %h want 200", pc); end
        wr_en = 1; wr_addr = 4'd14; wr_data = 32'h77;
        step();
        clear_inputs();
        exc_req = 1; exc_mode = 5'b10001; exc_vector = 32'h1C; exc_lr = 32'h204;
        step();
        clear_inputs();
        rd_addr = {4'd0, 4'd8, 4'd14};
        univ_rd_addr = 4'd14;
        #1;
        n_checks++; if (pc !== 32'h1C) begin n_fail++; $display("FAIL fiq_pc: got %h want 1c", pc); end
        n_checks++; if (cpsr !== 32'hD1) begin n_fail++; $display("FAIL fiq_cpsr: got %h want d1", cpsr); end
        n_checks++; if (spsr !== 32'h10) begin n_fail++; $display("FAIL fiq_spsr: got %h want 10", spsr); end
        n_checks++; if (rd_data[31:0] !== 32'h204) begin n_fail++; $display("FAIL fiq_r14: got %h want 204", rd_data[31:0]); end
        n_checks++; if (univ_rd_data !== 32'h77) begin n_fail++; $display("FAIL fiq_univ_r14: got %h want 77", univ_rd_data); end
        n_checks++; if (rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL fiq_r8: got %h want 0", rd_data[63:32]); end
        n_checks++; if (mode_err !== 1'b0) begin n_fail++; $display("FAIL fiq_mode_err: got %b want 0", mode_err); end
        exc_ret = 1;
        step();
        clear_inputs();
        n_checks++; if (cpsr !== 32'h10) begin n_fail++; $display("FAIL fiq_ret_cpsr: got %h want 10", cpsr); end
        n_checks++; if (rd_data[63:32] !== 32'h88) begin n_fail++; $display("FAIL ret_usr_r8: got %h want 88", rd_data[63:32]); end
        n_checks++; if (pc !== 32'h1C) begin n_fail++; $display("FAIL ret_pc_hold: got %h want 1c", pc); end
    endtask

    task automatic test_errors();
        cpsr_write = 1; cpsr_update = 32'h15;
        step();
        clear_inputs();
        n_checks++; if (cpsr !== 32'h10) begin n_fail++; $display("FAIL bad_cpsr_hold: got %h want 10", cpsr); end
        n_checks++; if (mode_err !== 1'b1) begin n_fail++; $display("FAIL bad_cpsr_err: got %b want 1", mode_err); end
        step();
        n_checks++; if (mode_err !== 1'b0) begin n_fail++; $display("FAIL bad_cpsr_err_pulse: got %b want 0", mode_err); end
        exc_req = 1; exc_mode = 5'b10000; exc_vector = 32'h300; exc_lr = 32'h999;
        univ_rd_addr = 4'd14;
        step();
        clear_inputs();
        n_checks++; if (pc !== 32'h1C) begin n_fail++; $display("FAIL bad_exc_pc: got %h want 1c", pc); end
        n_checks++; if (cpsr !== 32'h10) begin n_fail++; $display("FAIL bad_exc_cpsr: got %h want 10", cpsr); end
        n_checks++; if (mode_err !== 1'b1) begin n_fail++; $display("FAIL bad_exc_err: got %b want 1", mode_err); end
        n_checks++; if (univ_rd_data !== 32'h77) begin n_fail++; $display("FAIL bad_exc_r14: got %h want 77", univ_rd_data); end
        step();
        n_checks++; if (mode_err !== 1'b0) begin n_fail++; $display("FAIL bad_exc_err_pulse: got %b want 0", mode_err); end
        exc_ret = 1;
        step();
        clear_inputs();
        n_checks++; if (cpsr !== 32'h10) begin n_fail++; $display("FAIL usr_ret_cpsr: got %h want 10", cpsr); end
        n_checks++; if (mode_err !== 1'b1) begin n_fail++; $display("FAIL usr_ret_err: got %b want 1", mode_err); end
        spsr_write = 1; spsr_update = 32'hABC;
        step();
        clear_inputs();
        n_checks++; if (mode_err !== 1'b0) begin n_fail++; $display("FAIL usr_spsr_silent: got %b want 0", mode_err); end
        n_checks++; if (spsr !== 32'h0) begin n_fail++; $display("FAIL usr_spsr_ignored: got %h want 0", spsr); end
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 4'd3; wr_data = 32'hDEAD;
        rd_addr = {4'd0, 4'd0, 4'd3};
        univ_rd_addr = 4'd3;
        #1;
        n_checks++; if (rd_data[31:0] !== 32'hDEAD) begin n_fail++; $display("FAIL bypass_rd0: got %h want dead", rd_data[31:0]); end
        n_checks++; if (univ_rd_data !== 32'hDEAD) begin n_fail++; $display("FAIL bypass_univ: got %h want dead", univ_rd_data); end
        step();
        clear_inputs();
        n_checks++; if (rd_data[31:0] !== 32'hDEAD) begin n_fail++; $display("FAIL r3_commit: got %h want dead", rd_data[31:0]); end
        wr_en = 1; wr_addr = 4'd14; wr_data = 32'h1;
        exc_req = 1; exc_mode = 5'b10010; exc_vector = 32'h18; exc_lr = 32'h404;
        step();
        clear_inputs();
        rd_addr = {4'd0, 4'd0, 4'd14};
        univ_rd_addr = 4'd14;
        #1;
        n_checks++; if (univ_rd_data !== 32'h1) begin n_fail++; $display("FAIL coll_usr_r14: got %h want 1", univ_rd_data); end
        n_checks++; if (rd_data[31:0] !== 32'h404) begin n_fail++; $display("FAIL coll_irq_r14: got %h want 404", rd_data[31:0]); end
        n_checks++; if (cpsr !== 32'h92) begin n_fail++; $display("FAIL irq_cpsr: got %h want 92", cpsr); end
        n_checks++; if (spsr !== 32'h10) begin n_fail++; $display("FAIL irq_spsr: got %h want 10", spsr); end
        n_checks++; if (pc !== 32'h18) begin n_fail++; $display("FAIL irq_pc: got %h want 18", pc); end
        wr_en = 1; wr_addr = 4'd14; wr_data = 32'h55;
        exc_req = 1; exc_mode = 5'b10010; exc_vector = 32'h18; exc_lr = 32'h505;
        step();
        clear_inputs();
        #1;
        n_checks++; if (rd_data[31:0] !== 32'h505) begin n_fail++; $display("FAIL same_r14_exc_wins: got %h want 505", rd_data[31:0]); end
        n_checks++; if (spsr !== 32'h92) begin n_fail++; $display("FAIL nested_irq_spsr: got %h want 92", spsr); end
    endtask

    initial begin
        rst = 1;
        rd_addr = '0; univ_rd_addr = '0; wr_addr = '0; wr_data = '0;
        pc_update = '0; cpsr_update = '0; spsr_update = '0;
        exc_mode = '0; exc_vector = '0; exc_lr = '0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        test_reset();
        test_pc_step();
        test_banking();
        test_fiq_entry();
        test_errors();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
